unified_mem_arbiter: RTL and testbench

// Single-ported unified instruction/data memory with a two-requester arbiter.

---
 rtl/unified_mem_arbiter_if.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline (master) and the unified memory arbiter (slave).
// Carries the fetch port and the load/store port of the shared memory.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_stall;
    logic              if_valid;
    logic              if_err;
    logic [31:0]       if_rdata;

    logic              d_rd;
    logic              d_wr;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_stall;
    logic              d_valid;
    logic              d_err;
    logic [31:0]       d_rdata;

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_funct3, d_addr, d_wdata,
        input  if_stall, if_valid, if_err, if_rdata, d_stall, d_valid, d_err, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_funct3, d_addr, d_wdata,
        output if_stall, if_valid, if_err, if_rdata, d_stall, d_valid, d_err, d_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-ported unified instruction/data memory shared by the fetch port and
// the load/store port. One access is granted per cycle; data wins unless the
// fetch has already waited through STARVE_MAX consecutive data grants.
// Access flow: grant decided combinationally, the access (store write, word
// read) happens on the grant edge, formatted results appear one edge later.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_arbiter_if.slave   bus
);
    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_DATA,
        GRANT_FETCH
    } grant_e;

    logic [31:0]      mem [WORDS];

    grant_e           grantSel;
    logic             dReq;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       dSize;
    logic             dIllegal;
    logic             dMisaligned;
    logic             dErr;
    logic             fMis;
    logic [IDX_W-1:0] dIdx;
    logic [IDX_W-1:0] fIdx;
    logic             wrEn;
    logic [3:0]       wrBe;
    logic [31:0]      wrLanes;

    logic             dPend_q;
    logic             fPend_q;
    logic             err1_q;
    logic             store1_q;
    logic [2:0]       f3_1_q;
    logic [1:0]       off1_q;
    logic [31:0]      rdWord_q;

    logic [7:0]       selByte;
    logic [15:0]      selHalf;
    logic [31:0]      loadVal;

    logic             if_valid_q, if_err_q, d_valid_q, d_err_q;
    logic [31:0]      if_rdata_q, d_rdata_q;

    assign dReq  = bus.d_rd | bus.d_wr;
    assign dSize = bus.d_funct3[1:0];
    assign dIdx  = bus.d_addr[ADDR_W-1:2];
    assign fIdx  = bus.if_addr[ADDR_W-1:2];
    assign fMis  = (bus.if_addr[1:0] != 2'b00);

    // Pick who owns the array this cycle; nobody is granted while reset is held.
    always_comb begin
        grantSel = GRANT_NONE;
        if (!rst) begin
            if (dReq && (!bus.if_req || cnt_q < STARVE_LIM)) begin
                grantSel = GRANT_DATA;
            end else if (bus.if_req) begin
                grantSel = GRANT_FETCH;
            end
        end
    end

    // Count data grants that overtook a waiting fetch; any fetch grant or idle fetch port clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.if_req || grantSel == GRANT_FETCH) begin
            cnt_d = '0;
        end else if (grantSel == GRANT_DATA && cnt_q != STARVE_LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Classify the data request: illegal funct3, simultaneous rd/wr, or misaligned access.
    always_comb begin
        if (bus.d_wr) begin
            dIllegal = bus.d_rd | bus.d_funct3[2] | (dSize == 2'b11);
        end else begin
            dIllegal = (dSize == 2'b11) | (bus.d_funct3[2] & (dSize == 2'b10));
        end
        dMisaligned = ((dSize == 2'b01) & bus.d_addr[0]) |
                      ((dSize == 2'b10) & (bus.d_addr[1:0] != 2'b00));
        dErr = dIllegal | dMisaligned;
    end

    // Byte-lane enables and replicated write data so each store size lands in its own lanes.
    always_comb begin
        wrEn = (grantSel == GRANT_DATA) && bus.d_wr && !dErr;
        case (dSize)
            2'b00: begin
                wrBe    = 4'b0001 << bus.d_addr[1:0];
                wrLanes = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                wrBe    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                wrLanes = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                wrBe    = 4'b1111;
                wrLanes = bus.d_wdata;
            end
        endcase
    end

    // Memory array: byte-lane writes and a synchronous word read for whichever port is granted.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wrEn && wrBe[b]) begin
                mem[dIdx][8*b +: 8] <= wrLanes[8*b +: 8];
            end
        end
        rdWord_q <= mem[(grantSel == GRANT_FETCH) ? fIdx : dIdx];
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Capture what was granted so the result can be formatted on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dPend_q  <= 1'b0;
            fPend_q  <= 1'b0;
            err1_q   <= 1'b0;
            store1_q <= 1'b0;
            f3_1_q   <= 3'b000;
            off1_q   <= 2'b00;
        end else begin
            dPend_q  <= (grantSel == GRANT_DATA);
            fPend_q  <= (grantSel == GRANT_FETCH);
            err1_q   <= (grantSel == GRANT_DATA) ? dErr : ((grantSel == GRANT_FETCH) ? fMis : 1'b0);
            store1_q <= bus.d_wr;
            f3_1_q   <= bus.d_funct3;
            off1_q   <= bus.d_addr[1:0];
        end
    end

    // Extract and extend the loaded byte/half/word; stores and errors return zero.
    always_comb begin
        selByte = rdWord_q[{off1_q, 3'b000} +: 8];
        selHalf = rdWord_q[{off1_q[1], 4'b0000} +: 16];
        case (f3_1_q)
            3'b000:  loadVal = {{24{selByte[7]}}, selByte};
            3'b001:  loadVal = {{16{selHalf[15]}}, selHalf};
            3'b010:  loadVal = rdWord_q;
            3'b100:  loadVal = {24'h0, selByte};
            3'b101:  loadVal = {16'h0, selHalf};
            default: loadVal = 32'h0;
        endcase
        if (store1_q || err1_q) begin
            loadVal = 32'h0;
        end
    end

    // Registered one-cycle result pulses for both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= 32'h0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= 32'h0;
        end else begin
            d_valid_q  <= dPend_q;
            d_err_q    <= dPend_q & err1_q;
            d_rdata_q  <= dPend_q ? loadVal : 32'h0;
            if_valid_q <= fPend_q;
            if_err_q   <= fPend_q & err1_q;
            if_rdata_q <= fPend_q ? rdWord_q : 32'h0;
        end
    end

    assign bus.if_stall = !rst && bus.if_req && (grantSel != GRANT_FETCH);
    assign bus.d_stall  = !rst && dReq && (grantSel != GRANT_DATA);
    assign bus.if_valid = if_valid_q;
    assign bus.if_err   = if_err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.d_err    = d_err_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized traffic, all checked against a byte-array reference model.
module tb_unified_mem_arbiter;
    localparam int ADDR_W     = 9;
    localparam int STARVE_MAX = 3;
    localparam int BYTES      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    unified_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          dv;
        bit          de;
        logic [31:0] drd;
        bit          fv;
        bit          fe;
        logic [31:0] frd;
    } exp_t;

    logic [7:0] modelMem [BYTES];
    int         waitRun;
    exp_t       pipe;
    bit         lastGrantD, lastGrantF;
    logic       lastIfStall, lastDStall;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    // Compare one observed value with the model's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive every pipeline-side input of the bus.
    task automatic applyStimulus(input bit ifReq, input logic [8:0] ifAddr, input bit rd, input bit wr,
                                 input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wdata);
        bus.if_req   = ifReq;
        bus.if_addr  = ifAddr;
        bus.d_rd     = rd;
        bus.d_wr     = wr;
        bus.d_funct3 = f3;
        bus.d_addr   = addr;
        bus.d_wdata  = wdata;
    endtask

    function automatic logic [31:0] fetchWord(input int addr);
        int base;
        base = addr & ~3;
        return {modelMem[base+3], modelMem[base+2], modelMem[base+1], modelMem[base]};
    endfunction

    // Reference behaviour of one granted data access on the byte-addressed memory.
    task automatic modelData(input bit rd, input bit wr, input logic [2:0] f3, input int addr,
                             input logic [31:0] wdata, output bit err, output logic [31:0] rdata);
        int nbytes;
        bit legal;
        bit mis;
        logic [31:0] raw;
        case (f3[1:0])
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            2'b10:   nbytes = 4;
            default: nbytes = 0;
        endcase
        if (wr) legal = !rd && !f3[2] && nbytes != 0;
        else    legal = nbytes != 0 && !(f3[2] && nbytes == 4);
        mis   = (nbytes > 1) && ((addr % nbytes) != 0);
        err   = !legal || mis;
        rdata = 32'h0;
        raw   = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int k = 0; k < nbytes; k++) modelMem[addr+k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < nbytes; k++) raw[8*k +: 8] = modelMem[addr+k];
                rdata = raw;
                for (int b = 8*nbytes; b < 32; b++) rdata[b] = f3[2] ? 1'b0 : raw[8*nbytes-1];
            end
        end
    endtask

    // One clock cycle: check stalls against the arbitration rule, run the model, then check results due now.
    task automatic runCycle();
        exp_t cur;
        bit dReq, gD, gF, errV;
        logic [31:0] rdV;
        cur = '{default: '0};
        #2;
        dReq = bus.d_rd || bus.d_wr;
        gD   = dReq && (!bus.if_req || waitRun < STARVE_MAX);
        gF   = bus.if_req && !gD;
        lastIfStall = bus.if_stall;
        lastDStall  = bus.d_stall;
        checkOutput("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !gF));
        checkOutput("d_stall", 32'(bus.d_stall), 32'(dReq && !gD));
        if (gD) begin
            modelData(bus.d_rd, bus.d_wr, bus.d_funct3, int'(bus.d_addr), bus.d_wdata, errV, rdV);
            cur.dv  = 1'b1;
            cur.de  = errV;
            cur.drd = rdV;
        end
        if (gF) begin
            cur.fv  = 1'b1;
            cur.fe  = (bus.if_addr[1:0] != 2'b00);
            cur.frd = fetchWord(int'(bus.if_addr));
        end
        if (!bus.if_req || gF) waitRun = 0;
        else waitRun++;
        lastGrantD = gD;
        lastGrantF = gF;
        @(posedge clk);
        #1;
        checkOutput("d_valid", 32'(bus.d_valid), 32'(pipe.dv));
        checkOutput("d_err", 32'(bus.d_err), 32'(pipe.de));
        checkOutput("if_valid", 32'(bus.if_valid), 32'(pipe.fv));
        checkOutput("if_err", 32'(bus.if_err), 32'(pipe.fe));
        if (pipe.dv) checkOutput("d_rdata", bus.d_rdata, pipe.drd);
        if (pipe.fv && !$isunknown(pipe.frd)) checkOutput("if_rdata", bus.if_rdata, pipe.frd);
        pipe = cur;
    endtask

    // A single data access with the fetch port idle, followed by the cycle that shows its result.
    task automatic dataOp(input bit rd, input bit wr, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wdata);
        applyStimulus(1'b0, 9'h0, rd, wr, f3, addr, wdata);
        runCycle();
        applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        runCycle();
    endtask

    function automatic logic [8:0] randAddr(input logic [2:0] f3);
        logic [8:0] a;
        a = 9'($urandom);
        if ($urandom % 4 != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        end
        return a;
    endfunction

    logic [7:0]  ifStallBits, dStallBits;
    bit          pendD, pendF, rRd, rWr;
    logic [2:0]  rF3;
    logic [8:0]  rAddr, rIfAddr;
    logic [31:0] rWdata;
    int          sel;

    initial begin
        for (int i = 0; i < BYTES; i++) modelMem[i] = 8'hxx;
        pipe    = '{default: '0};
        waitRun = 0;

        // Reset held with both ports requesting: every output must stay low.
        rst = 1'b1;
        applyStimulus(1'b1, 9'h004, 1'b1, 1'b1, 3'b010, 9'h008, 32'h1111_2222);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_if_stall", 32'(bus.if_stall), 32'h0);
        checkOutput("rst_d_stall", 32'(bus.d_stall), 32'h0);
        checkOutput("rst_if_valid", 32'(bus.if_valid), 32'h0);
        checkOutput("rst_if_err", 32'(bus.if_err), 32'h0);
        checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
        checkOutput("rst_d_valid", 32'(bus.d_valid), 32'h0);
        checkOutput("rst_d_err", 32'(bus.d_err), 32'h0);
        checkOutput("rst_d_rdata", bus.d_rdata, 32'h0);
        rst = 1'b0;

        // First fetch after reset.
        applyStimulus(1'b1, 9'h000, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        runCycle();
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        runCycle();
        checkOutput("fetch0_valid", 32'(bus.if_valid), 32'h1);
        runCycle();
        checkOutput("fetch0_pulse_end", 32'(bus.if_valid), 32'h0);

        // Give every word a known value.
        for (int w = 0; w < BYTES / 4; w++) begin
            applyStimulus(1'b0, 9'h0, 1'b0, 1'b1, 3'b010, 9'(w * 4), $urandom);
            runCycle();
        end
        applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        runCycle();
        runCycle();

        // Word store then word load.
        dataOp(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF);
        dataOp(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        checkOutput("lw_deadbeef", bus.d_rdata, 32'hDEAD_BEEF);
        checkOutput("lw_deadbeef_err", 32'(bus.d_err), 32'h0);

        // Byte store and signed/unsigned byte loads.
        dataOp(1'b0, 1'b1, 3'b000, 9'h013, 32'h0000_0080);
        dataOp(1'b1, 1'b0, 3'b000, 9'h013, 32'h0);
        checkOutput("lb_sign", bus.d_rdata, 32'hFFFF_FF80);
        dataOp(1'b1, 1'b0, 3'b100, 9'h013, 32'h0);
        checkOutput("lbu_zero", bus.d_rdata, 32'h0000_0080);
        dataOp(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        checkOutput("lw_after_sb", bus.d_rdata, 32'h80AD_BEEF);

        // Misaligned half load and word store are rejected without side effects.
        dataOp(1'b1, 1'b0, 3'b001, 9'h011, 32'h0);
        checkOutput("lh_mis_err", 32'(bus.d_err), 32'h1);
        checkOutput("lh_mis_rdata", bus.d_rdata, 32'h0);
        dataOp(1'b0, 1'b1, 3'b010, 9'h012, 32'h1234_5678);
        checkOutput("sw_mis_err", 32'(bus.d_err), 32'h1);
        dataOp(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        checkOutput("lw_unchanged", bus.d_rdata, 32'h80AD_BEEF);

        // Read and write together behave as an erroring store.
        dataOp(1'b1, 1'b1, 3'b010, 9'h020, 32'h5555_AAAA);
        checkOutput("rdwr_err", 32'(bus.d_err), 32'h1);

        // Starvation bound: fetch held while data streams back to back.
        applyStimulus(1'b1, 9'h100, 1'b1, 1'b0, 3'b010, 9'h040, 32'h0);
        for (int i = 0; i < 8; i++) begin
            runCycle();
            ifStallBits[i] = lastIfStall;
            dStallBits[i]  = lastDStall;
        end
        applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        runCycle();
        runCycle();
        checkOutput("starve_if_stall", 32'(ifStallBits), 32'h0000_0077);
        checkOutput("starve_d_stall", 32'(dStallBits), 32'h0000_0088);

        // Reset right after a load grant drops its pulse but keeps earlier stores.
        dataOp(1'b0, 1'b1, 3'b010, 9'h040, 32'hCAFE_F00D);
        applyStimulus(1'b0, 9'h0, 1'b1, 1'b0, 3'b010, 9'h040, 32'h0);
        runCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        pipe    = '{default: '0};
        waitRun = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_drop_d_valid", 32'(bus.d_valid), 32'h0);
        end
        rst = 1'b0;
        runCycle();
        dataOp(1'b1, 1'b0, 3'b010, 9'h040, 32'h0);
        checkOutput("lw_after_rst", bus.d_rdata, 32'hCAFE_F00D);

        // Randomized traffic on both ports, requests held until granted.
        pendD   = 1'b0;
        pendF   = 1'b0;
        rRd     = 1'b0;
        rWr     = 1'b0;
        rF3     = 3'b000;
        rAddr   = 9'h0;
        rIfAddr = 9'h0;
        rWdata  = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if (!pendD && ($urandom % 3 == 0)) begin
                sel = int'($urandom % 8);
                rRd = (sel < 4) || (sel == 7);
                rWr = (sel >= 4);
                if ($urandom % 4 == 0) begin
                    rF3 = 3'($urandom);
                end else begin
                    rF3 = 3'($urandom % 3);
                    if (!rWr && rF3 != 3'b010 && ($urandom % 2 == 0)) rF3[2] = 1'b1;
                end
                rAddr  = randAddr(rF3);
                rWdata = $urandom;
                pendD  = 1'b1;
            end else if (pendD && ($urandom % 5 == 0)) begin
                rAddr  = randAddr(rF3);
                rWdata = $urandom;
            end
            if (!pendF && ($urandom % 2 == 0)) begin
                pendF   = 1'b1;
                rIfAddr = 9'($urandom);
                if ($urandom % 8 != 0) rIfAddr[1:0] = 2'b00;
            end
            applyStimulus(pendF, rIfAddr, pendD && rRd, pendD && rWr, rF3, rAddr, rWdata);
            runCycle();
            if (lastGrantD) pendD = 1'b0;
            if (lastGrantF) pendF = 1'b0;
        end
        applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
        runCycle();
        runCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
